// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter in front of a single-port data RAM.
// Latency: grant and RAM strobe are combinational in the request cycle; the response arrives one cycle later.
// Backpressure: a requester that is not granted must hold its request; one grant and one response every cycle.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   m{0,1}_req/we/be/addr/wdata_i      requester transaction inputs
//   m{0,1}_gnt_o                       request accepted this cycle
//   m{0,1}_rvalid/rdata/err_o          response, one cycle after the grant
//   ram_req/we/be/addr/wdata_o         RAM access (address relative to RAM_BASE)
//   ram_rdata_i                        RAM read data, valid one cycle after ram_req_o
//
// Optional feature: define DMEM_ARB_RANGE_CHECK_EN to reject granted accesses
// outside [RAM_BASE, RAM_BASE+RAM_SIZE) with an error response instead of a RAM access.
module dmem_arbiter #(
  parameter logic [31:0] RAM_BASE = 32'h3000,
  parameter logic [31:0] RAM_SIZE = 32'h1000
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  logic        rr_q, rr_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic        rsp_own_q, rsp_own_d;

  logic        gnt0, gnt1, gnt_any, win;
  logic        win_we;
  logic [3:0]  win_be;
  logic [31:0] win_off;
  logic [31:0] win_wdata;
  logic        ram_en;
  logic        rsp_data_ok;

  // Round-robin: m0 wins unless m1 also requests and the pointer favours m1.
  always_comb begin
    gnt0    = m0_req_i & (~m1_req_i | ~rr_q);
    gnt1    = m1_req_i & ~gnt0;
    gnt_any = gnt0 | gnt1;
    win     = gnt1;

    win_we    = win ? m1_we_i    : m0_we_i;
    win_be    = win ? m1_be_i    : m0_be_i;
    win_wdata = win ? m1_wdata_i : m0_wdata_i;
    // Offset into the RAM window; for addresses below the base this wraps
    // to a large value, which the range check relies on.
    win_off   = (win ? m1_addr_i : m0_addr_i) - RAM_BASE;

    // Pointer moves to the loser so it wins the next contested cycle.
    rr_d      = gnt_any ? ~win : rr_q;
    rsp_vld_d = gnt_any;
    rsp_own_d = win;
  end

`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic rsp_err_q, rsp_err_d;
  logic in_range;

  always_comb begin
    in_range  = (win_off < RAM_SIZE);
    ram_en    = gnt_any & in_range;
    rsp_err_d = gnt_any & ~in_range;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_data_ok = ~rsp_err_q;
  assign m0_err_o    = m0_rvalid_o & rsp_err_q;
  assign m1_err_o    = m1_rvalid_o & rsp_err_q;
`else
  assign ram_en      = gnt_any;
  assign rsp_data_ok = 1'b1;
  assign m0_err_o    = 1'b0;
  assign m1_err_o    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_own_q <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_own_q <= rsp_own_d;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;

  // A rejected access must not write, so the write enable follows the strobe.
  assign ram_req_o   = ram_en;
  assign ram_we_o    = ram_en & win_we;
  assign ram_be_o    = win_be;
  assign ram_addr_o  = win_off;
  assign ram_wdata_o = win_wdata;

  assign m0_rvalid_o = rsp_vld_q & ~rsp_own_q;
  assign m1_rvalid_o = rsp_vld_q &  rsp_own_q;
  // Idle requesters and error responses see zero read data.
  assign m0_rdata_o  = (m0_rvalid_o & rsp_data_ok) ? ram_rdata_i : 32'h0;
  assign m1_rdata_o  = (m1_rvalid_o & rsp_data_ok) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam logic [31:0] BASE = 32'h3000;
  localparam logic [31:0] SIZE = 32'h1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_gnt, m0_we, m0_rvalid, m0_err;
  logic [3:0]  m0_be;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_gnt, m1_we, m1_rvalid, m1_err;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        ram_req, ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.RAM_BASE(BASE), .RAM_SIZE(SIZE)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid),
    .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- RAM behind the arbiter ----------------
  logic [31:0] ram_mem [0:1023];
  logic [31:0] mdl_mem [0:1023];

  initial begin
    for (int k = 0; k < 1024; k++) begin
      ram_mem[k] = 32'hA5A50000 ^ 32'(k);
      mdl_mem[k] = 32'hA5A50000 ^ 32'(k);
    end
  end

  always @(posedge clk) begin
    if (rst_n && ram_req) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) ram_mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram_mem[ram_addr[11:2]];
      end
    end
  end

  // ---------------- behavioural model ----------------
  // State: which requester wins a tie, and the one response owed next cycle.
  bit          fav = 0;
  bit          pend = 0, p_own = 0, p_err = 0, p_rd = 0;
  logic [31:0] p_data = 32'h0;
  bit          n_pend = 0, n_own = 0, n_err = 0, n_rd = 0, n_fav = 0, n_wr = 0;
  logic [31:0] n_data = 32'h0, n_wdat = 32'h0;
  logic [3:0]  n_be = 4'h0;
  logic [9:0]  n_idx = 10'h0;

  function automatic bit in_window(input logic [31:0] a);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(SIZE));
`else
    return 1'b1;
`endif
  endfunction

  always @(negedge clk) begin : cmp
    bit          g0, g1, w, inr, we;
    logic [31:0] a, off;
    // response side
    chk("m0_rvalid", 32'(m0_rvalid), 32'(pend && !p_own));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(pend &&  p_own));
    chk("m0_err",    32'(m0_err),    32'(pend && !p_own && p_err));
    chk("m1_err",    32'(m1_err),    32'(pend &&  p_own && p_err));
    if (!(pend && !p_own))   chk("m0_rdata_idle", m0_rdata, 32'h0);
    else if (p_err)          chk("m0_rdata_err",  m0_rdata, 32'h0);
    else if (p_rd)           chk("m0_rdata",      m0_rdata, p_data);
    if (!(pend && p_own))    chk("m1_rdata_idle", m1_rdata, 32'h0);
    else if (p_err)          chk("m1_rdata_err",  m1_rdata, 32'h0);
    else if (p_rd)           chk("m1_rdata",      m1_rdata, p_data);
    // request side
    g0 = m0_req && (!m1_req || !fav);
    g1 = m1_req && !g0;
    chk("m0_gnt", 32'(m0_gnt), 32'(g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(g1));
    w   = g1;
    a   = w ? m1_addr : m0_addr;
    we  = w ? m1_we : m0_we;
    inr = in_window(a);
    off = a - BASE;
    chk("ram_req", 32'(ram_req), 32'((g0 || g1) && inr));
    if ((g0 || g1) && inr) begin
      chk("ram_addr",  ram_addr, off);
      chk("ram_we",    32'(ram_we), 32'(we));
      chk("ram_be",    32'(ram_be), 32'(w ? m1_be : m0_be));
      if (we) chk("ram_wdata", ram_wdata, w ? m1_wdata : m0_wdata);
    end
    n_pend = g0 || g1;
    n_own  = w;
    n_err  = !inr;
    n_rd   = !we;
    n_idx  = off[11:2];
    n_data = inr ? mdl_mem[off[11:2]] : 32'h0;
    n_wr   = n_pend && inr && we;
    n_be   = w ? m1_be : m0_be;
    n_wdat = w ? m1_wdata : m0_wdata;
    n_fav  = n_pend ? !w : fav;  // loser gets priority next time
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fav  = 0;
      pend = 0;
    end else if (clk) begin
      if (n_wr)
        for (int b = 0; b < 4; b++)
          if (n_be[b]) mdl_mem[n_idx][8*b +: 8] = n_wdat[8*b +: 8];
      fav    = n_fav;
      pend   = n_pend;
      p_own  = n_own;
      p_err  = n_err;
      p_rd   = n_rd;
      p_data = n_data;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    m0_req = req; m0_we = we; m0_be = 4'hF; m0_addr = addr; m0_wdata = wd;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    m1_req = req; m1_we = we; m1_be = 4'hF; m1_addr = addr; m1_wdata = wd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] seq;
    int cnt;
    rst_n = 1'b0;
    set_m0(1'b1, 1'b0, 32'h3000, 32'h0);
    set_m1(1'b1, 1'b0, 32'h3004, 32'h0);

    // reset state: responses idle, tie goes to m0
    @(negedge clk);
    chk("rst_gnt0",    32'(m0_gnt),    32'd1);
    chk("rst_rvalid0", 32'(m0_rvalid), 32'd0);
    chk("rst_rvalid1", 32'(m1_rvalid), 32'd1 - 32'd1);
    nxt();
    @(negedge clk);
    chk("rst_hold_rvalid0", 32'(m0_rvalid), 32'd0);
    nxt();
    rst_n = 1'b1;
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    nxt();

    // single-requester write then read
    set_m0(1'b1, 1'b1, 32'h3010, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_gnt0",  32'(m0_gnt), 32'd1);
    chk("wr_addr",  ram_addr, 32'h10);
    chk("wr_wdata", ram_wdata, 32'hDEADBEEF);
    nxt();
    set_m0(1'b1, 1'b0, 32'h3010, 32'h0);
    @(negedge clk);
    chk("rd_gnt0",       32'(m0_gnt), 32'd1);
    chk("rd_addr",       ram_addr, 32'h10);
    chk("wr_rsp_rvalid", 32'(m0_rvalid), 32'd1);
    nxt();
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rd_rsp_rvalid", 32'(m0_rvalid), 32'd1);
    chk("rd_rsp_rdata",  m0_rdata, 32'hDEADBEEF);
    chk("rd_rsp_err",    32'(m0_err), 32'd0);
    nxt();

    // contested requests alternate m0, m1, m0, m1 after reset
    do_reset();
    set_m0(1'b1, 1'b0, 32'h3020, 32'h0);
    set_m1(1'b1, 1'b0, 32'h3024, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seq[k] = m0_gnt;
      nxt();
    end
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rr_order", 32'(seq), 32'h5);
    chk("rr_last_rvalid1", 32'(m1_rvalid), 32'd1);
    nxt();

    // m1 alone three times, then the tie goes to m0
    cnt = 0;
    set_m1(1'b1, 1'b0, 32'h3030, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cnt += int'(m1_gnt);
      nxt();
    end
    set_m0(1'b1, 1'b0, 32'h3034, 32'h0);
    @(negedge clk);
    chk("solo_m1_grants", 32'(cnt), 32'd3);
    chk("tie_after_solo_gnt0", 32'(m0_gnt), 32'd1);
    nxt();

    // out-of-window read from m1
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b1, 1'b0, 32'h4000, 32'h0);
    @(negedge clk);
    chk("oor_gnt1", 32'(m1_gnt), 32'd1);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    chk("oor_ram_req", 32'(ram_req), 32'd0);
`else
    chk("oor_ram_req", 32'(ram_req), 32'd1);
`endif
    nxt();
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("oor_rvalid1", 32'(m1_rvalid), 32'd1);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    chk("oor_err1",   32'(m1_err), 32'd1);
    chk("oor_rdata1", m1_rdata, 32'h0);
`else
    chk("oor_err1",   32'(m1_err), 32'd0);
`endif
    nxt();

    // reset right after a grant drops the response and the pointer
    set_m0(1'b1, 1'b0, 32'h3040, 32'h0);
    nxt();                                   // m0 granted: pointer now favours m1
    set_m1(1'b1, 1'b0, 32'h3044, 32'h0);
    @(negedge clk);
    chk("pre_rst_gnt1", 32'(m1_gnt), 32'd1);
    nxt();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_drop_rvalid1", 32'(m1_rvalid), 32'd0);
    chk("rst_drop_rvalid0", 32'(m0_rvalid), 32'd0);
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt0", 32'(m0_gnt), 32'd1);
    nxt();

    // mixed traffic sweep, model checks every cycle
    for (int i = 0; i < 400; i++) begin
      m0_req   = (i % 3) != 0;
      m1_req   = (i % 5) < 3;
      m0_we    = i[1];
      m1_we    = i[2] ^ i[0];
      m0_be    = 4'(i * 7) | 4'h1;
      m1_be    = 4'(i * 5) | 4'h8;
      m0_addr  = (i % 11 == 0) ? 32'h2FF0 : 32'h3000 + 32'((i % 16) * 4);
      m1_addr  = (i % 13 == 0) ? 32'h4004 : 32'h3000 + 32'(((i * 3) % 16) * 4);
      m0_wdata = 32'h1000_0000 + 32'(i * 32'h10203);
      m1_wdata = 32'h2000_0000 ^ 32'(i * 32'h30405);
      nxt();
    end
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    nxt();
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter RAM_BASE, default 32'h3000, meaning the byte base address of the shared RAM window.
REQ-002 The block SHALL have parameter RAM_SIZE, default 32'h1000, meaning the byte size of the RAM window.
REQ-003 The block SHALL have port clk_i  in  1  the single clock; all state on the rising edge.
REQ-004 The block SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports m{0,1}_req_i  in  1  requester N transaction request.
REQ-006 The block SHALL have ports m{0,1}_gnt_o  out  1  requester N request accepted this cycle.
REQ-007 The block SHALL have ports m{0,1}_we_i  in  1  requester N write enable.
REQ-008 The block SHALL have ports m{0,1}_be_i  in  4  requester N byte enables.
REQ-009 The block SHALL have ports m{0,1}_addr_i  in  32  requester N byte address.
REQ-010 The block SHALL have ports m{0,1}_wdata_i  in  32  requester N write data.
REQ-011 The block SHALL have ports m{0,1}_rvalid_o  out  1  requester N response valid.
REQ-012 The block SHALL have ports m{0,1}_rdata_o  out  32  requester N read data.
REQ-013 The block SHALL have ports m{0,1}_err_o  out  1  requester N error, qualified by m{0,1}_rvalid_o.
REQ-014 The block SHALL have port ram_req_o  out  1  RAM access strobe.
REQ-015 The block SHALL have port ram_we_o  out  1  RAM write enable.
REQ-016 The block SHALL have port ram_be_o  out  4  RAM byte enables.
REQ-017 The block SHALL have port ram_addr_o  out  32  RAM address, equal to the winner's address minus RAM_BASE.
REQ-018 The block SHALL have port ram_wdata_o  out  32  RAM write data.
REQ-019 The block SHALL have port ram_rdata_i  in  32  RAM read data, valid exactly one cycle after ram_req_o.

Function
REQ-020 Arbitration SHALL be combinational; at most one mN_gnt_o SHALL be high per cycle, and a grant SHALL be issued only to a requester with mN_req_i high.
REQ-021 With a single requester active, that requester SHALL be granted in the same cycle.
REQ-022 With both requesters active, the grant SHALL go to the requester selected by the round-robin pointer rr_q (0 selects m0, 1 selects m1).
REQ-023 After every grant, rr_q SHALL update to the index of the loser (the requester not granted); rr_q SHALL hold when no grant is issued.
REQ-024 When a grant is issued, ram_req_o, ram_we_o, ram_be_o, ram_addr_o and ram_wdata_o SHALL carry the winner's signals in the same cycle.
REQ-025 Registers rsp_vld_q, rsp_own_q and rsp_err_q SHALL capture grant-issued, winner index and error flag, respectively, at each clock edge.
REQ-026 In the cycle after a grant, m[rsp_own_q]_rvalid_o SHALL be 1 and m[rsp_own_q]_rdata_o SHALL equal ram_rdata_i; the other requester's rvalid SHALL be 0.
REQ-027 The rdata output of a requester not receiving a response SHALL be 0.
REQ-028 A write SHALL also produce an rvalid pulse; rdata on that pulse is don't-care.
REQ-029 Back-to-back grants SHALL be supported at full throughput: one grant and one response per cycle.

Reset
REQ-030 While rst_ni is 0, rr_q, rsp_vld_q, rsp_own_q and rsp_err_q SHALL be 0, so all rvalid_o and err_o outputs are 0.
REQ-031 A response pending when reset is asserted SHALL be discarded.
REQ-032 The first arbitration after reset SHALL favour m0.

Configuration
REQ-033 Address range checking SHALL be controlled by the macro DMEM_ARB_RANGE_CHECK_EN.
REQ-034 With DMEM_ARB_RANGE_CHECK_EN defined, a granted address outside [RAM_BASE, RAM_BASE+RAM_SIZE) SHALL be granted normally, SHALL NOT assert ram_req_o, and SHALL return rvalid=1, err=1, rdata=0 in the next cycle; writes to such an address SHALL have no effect.
REQ-035 With DMEM_ARB_RANGE_CHECK_EN undefined, every grant SHALL access the RAM, m{0,1}_err_o SHALL be tied to 0, and no range logic SHALL exist.

Verification
REQ-036 m0 writes 32'hDEADBEEF to 0x3010, then reads 0x3010 -> m0_gnt_o=1 on each request; ram_addr_o=0x10 on both accesses; the read response arrives one cycle later with rdata=32'hDEADBEEF, err=0.
REQ-037 m0 and m1 both hold req for 4 cycles after reset -> grants issue in order m0, m1, m0, m1; each rvalid follows its grant by one cycle.
REQ-038 Only m1 requests for 3 cycles, then both request -> m1 is granted 3 times, then m0 is granted (rr_q=0).
REQ-039 With DMEM_ARB_RANGE_CHECK_EN defined, m1 reads 0x4000 -> ram_req_o=0; the next cycle gives m1_rvalid_o=1, m1_err_o=1, m1_rdata_o=0. With the macro undefined, the same read gives ram_req_o=1 and err=0.
REQ-040 Assert rst_ni=0 in the cycle after a grant -> no rvalid appears; after release, simultaneous requests grant m0 first.
